fastreadout_packetizer: RTL and testbench

Parametrised capture-and-packetise stage for the fast readout path. Accepts a stream of DATA_W-bit samples and buffers DEPTH of them into a frame. It then emits each frame as a framed packet (sync, header, payload, checksum) over a valid/ready output. Samples that arrive while a packet is being sent are dropped, counted, and flagged in the next packet header. It sits between the input shift-register stage and the packet router.

---
 rtl/fastreadout_packetizer.sv | 176 +++++++++++++++++
 tb/tb_fastreadout_packetizer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fastreadout_packetizer.sv
// fastreadout_packetizer
// Buffers DEPTH samples into a frame, then sends it as a packet
// (sync, header, payload, checksum) over a valid/ready output. Samples
// arriving while a packet is in flight are dropped, counted, and flagged
// in the header of the next packet.
`timescale 1ns/1ps

module fastreadout_packetizer #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SEQ_W = DATA_W - 1;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);

    typedef enum logic [2:0] {
        FILL = 3'd0,
        SYNC = 3'd1,
        HDR  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4
    } state_t;

    state_t state, state_d;

    logic [DATA_W-1:0] buf_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [DATA_W-1:0] data_sum;
    logic [SEQ_W-1:0]  seq;
    logic              frame_ovf;
    logic              ovf_pending;
    logic [DATA_W-1:0] header;
    logic [DATA_W-1:0] out_data_d;
    logic              out_last_d;

    logic accept;
    logic drop;
    logic xfer;

    assign accept    = in_valid & ena & (state == FILL);
    assign drop      = in_valid & ena & (state != FILL);
    assign out_valid = (state != FILL);
    assign busy      = (state != FILL);
    assign xfer      = out_valid & out_ready;
    assign header    = {frame_ovf, seq};

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_d;
    end

    // Next-state logic: every packet state advances only on a transfer.
    // NOTE: a default assignment heads every always_comb so no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        state_d = state;
        case (state)
            FILL: if (accept && wr_ptr == LAST_IDX) state_d = SYNC;
            SYNC: if (xfer)                         state_d = HDR;
            HDR:  if (xfer)                         state_d = DATA;
            DATA: if (xfer && rd_ptr == LAST_IDX)   state_d = CSUM;
            CSUM: if (xfer)                         state_d = FILL;
            default:                                state_d = FILL;
        endcase
    end

    // Read pointer advance: steps through the payload, clears after the packet.
    always_comb begin
        rd_ptr_d = rd_ptr;
        if (state == DATA && xfer && rd_ptr != LAST_IDX) rd_ptr_d = rd_ptr + PTR_ONE;
        else if (state == CSUM && xfer)                  rd_ptr_d = '0;
    end

    // Output word for the state being entered; registered below so that
    // out_data/out_last hold stable whenever no transfer happens.
    always_comb begin
        out_data_d = '0;
        out_last_d = 1'b0;
        case (state_d)
            SYNC: out_data_d = SYNC_WORD;
            HDR:  out_data_d = header;
            DATA: out_data_d = buf_mem[rd_ptr_d];
            CSUM: begin
                out_data_d = header + data_sum;
                out_last_d = 1'b1;
            end
            default: out_data_d = '0;
        endcase
    end

    // Output word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            out_data <= out_data_d;
            out_last <= out_last_d;
        end
    end

    // Sample buffer write.
    // NOTE: the buffer has no reset; every entry is written before it is
    // read, and leaving it out keeps the array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (accept) buf_mem[wr_ptr] <= in_data;
    end

    // Capture pointer and running payload sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            data_sum <= '0;
        end else if (accept) begin
            wr_ptr   <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_ONE;
            data_sum <= data_sum + in_data;
        end else if (state == CSUM && xfer) begin
            data_sum <= '0;
        end
    end

    // Payload read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ptr <= '0;
        else        rd_ptr <= rd_ptr_d;
    end

    // Packet sequence number, bumped once per completed packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     seq <= '0;
        else if (state == CSUM && xfer) seq <= seq + SEQ_ONE;
    end

    // Overflow tracking: drops arm ovf_pending, the first sample of the next
    // frame moves it into that frame's header flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_pending <= 1'b0;
            frame_ovf   <= 1'b0;
        end else if (accept && wr_ptr == '0) begin
            frame_ovf   <= ovf_pending;
            ovf_pending <= 1'b0;
        end else if (drop) begin
            ovf_pending <= 1'b1;
        end
    end

    // Saturating drop counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end

endmodule

// File: tb/tb_fastreadout_packetizer.sv
// Self-checking bench for fastreadout_packetizer: a reference model queues
// every expected packet word as frames are driven; a monitor compares the
// DUT output against the queue head on every valid cycle.
`timescale 1ns/1ps

module tb_fastreadout_packetizer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic [7:0]        drop_cnt;

    fastreadout_packetizer #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .SYNC_WORD (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    word_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int xfer_cnt = 0;
    int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: never ready

    // Reference model state
    logic [DATA_W-2:0] m_seq  = '0;
    logic              m_pend = 1'b0;
    int                m_drop = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d, input logic l);
        word_t w;
        w.data = d;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Drive one frame of DEPTH samples (start + i*step) and queue its packet.
    task automatic send_frame(input logic [DATA_W-1:0] start, input logic [DATA_W-1:0] step);
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] hdr;
        logic [DATA_W-1:0] csum;
        sum    = '0;
        hdr    = {m_pend, m_seq};
        m_pend = 1'b0;
        push_word(8'hA5, 1'b0);
        push_word(hdr, 1'b0);
        d = start;
        for (int i = 0; i < DEPTH; i++) begin
            push_word(d, 1'b0);
            sum      = sum + d;
            in_valid = 1'b1;
            in_data  = d;
            @(posedge clk);
            #1;
            d = d + step;
        end
        in_valid = 1'b0;
        csum = hdr + sum;
        push_word(csum, 1'b1);
        m_seq = m_seq + 1'b1;
    endtask

    // Drive n samples while the DUT is busy; each one must be dropped.
    task automatic drop_samples(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h5A;
            @(posedge clk);
            #1;
            if (m_drop < 255) m_drop++;
            m_pend = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the packet to drain and the DUT to return to FILL.
    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                check("idle_valid", out_valid, 1'b0);
                check("idle_data", out_data, 8'h00);
                check("idle_last", out_last, 1'b0);
                return;
            end
        end
        check("idle_timeout", busy, 1'b0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        m_seq  = '0;
        m_pend = 1'b0;
        m_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // out_ready pattern generator
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_valid", out_valid, 1'b0);
                end else begin
                    check(out_ready ? "word" : "stall_word", out_data, exp_q[0].data);
                    check(out_ready ? "last" : "stall_last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        logic hit;
        rst_n    = 1'b0;
        ena      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset values
        #12;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop_cnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: A5, 00, 01..10, 88
        send_frame(8'h01, 8'h01);
        wait_idle(100);

        // Backpressure with out_ready toggling
        rdy_mode = 1;
        send_frame(8'h01, 8'h01);
        wait_idle(200);
        rdy_mode = 0;

        // Overflow flag: 3 drops during packet 0, then 16x0xFF -> hdr 81, csum 71
        do_reset();
        send_frame(8'h10, 8'h03);
        drop_samples(3);
        check("drop_3", drop_cnt, m_drop);
        wait_idle(100);
        send_frame(8'hFF, 8'h00);
        wait_idle(100);
        send_frame(8'h40, 8'h01);
        wait_idle(100);

        // ena low in FILL: nothing captured, nothing counted
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (5) @(posedge clk);
        #1;
        check("ena_fill_drop", drop_cnt, m_drop);
        check("ena_fill_busy", busy, 1'b0);
        in_valid = 1'b0;
        ena      = 1'b1;

        // ena low while busy: no drop counting
        send_frame(8'h03, 8'h05);
        ena      = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ena_busy_drop", drop_cnt, m_drop);
        in_valid = 1'b0;
        ena      = 1'b1;
        wait_idle(100);

        // Saturation: 300 drops while stalled
        rdy_mode = 2;
        send_frame(8'h05, 8'h07);
        drop_samples(300);
        check("drop_sat", drop_cnt, 8'hFF);
        rdy_mode = 0;
        wait_idle(100);

        // Reset during the 6th DATA word
        send_frame(8'h20, 8'h01);
        target = xfer_cnt + 7;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            if (xfer_cnt >= target) hit = 1'b1;
        end
        check("mid_reach", hit, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_data", out_data, 8'h00);
        check("mid_rst_last", out_last, 1'b0);
        check("mid_rst_drop", drop_cnt, 8'h00);
        exp_q.delete();
        m_seq  = '0;
        m_pend = 1'b0;
        m_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h00, 8'h00);
        wait_idle(100);

        // Sequence wrap: 129 frames, seq 0..127 then 0
        do_reset();
        for (int f = 0; f < 129; f++) begin
            send_frame(8'(f), 8'h01);
            wait_idle(100);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
